// File: rtl/tank_shell_scheduler_if.sv
// Spawn-command bus between the shell scheduler and the game logic around it.
// The master side is keyboard/tank/ball logic; the slave side is the scheduler.
interface tank_shell_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic [1:0]           fire_req;
  logic [9:0]           tank0_x;
  logic [9:0]           tank0_y;
  logic [9:0]           tank1_x;
  logic [9:0]           tank1_y;
  logic [1:0]           tank0_dir;
  logic [1:0]           tank1_dir;
  logic [NUM_SLOTS-1:0] hit;

  logic                 spawn_valid;
  logic [2:0]           spawn_slot;
  logic                 spawn_owner;
  logic [9:0]           spawn_x;
  logic [9:0]           spawn_y;
  logic [1:0]           spawn_dir;
  logic [NUM_SLOTS-1:0] slot_busy;
  logic [NUM_SLOTS-1:0] slot_owner;

  modport master (
    output fire_req, tank0_x, tank0_y, tank1_x, tank1_y, tank0_dir, tank1_dir, hit,
    input  spawn_valid, spawn_slot, spawn_owner, spawn_x, spawn_y, spawn_dir,
           slot_busy, slot_owner
  );

  modport slave (
    input  fire_req, tank0_x, tank0_y, tank1_x, tank1_y, tank0_dir, tank1_dir, hit,
    output spawn_valid, spawn_slot, spawn_owner, spawn_x, spawn_y, spawn_dir,
           slot_busy, slot_owner
  );
endinterface

// File: rtl/tank_shell_scheduler.sv
// Round-robin shell slot allocator for two tanks: per-player quota and cooldown,
// one registered spawn command per grant, per-slot lifetime down-counters.
module tank_shell_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int LIFETIME  = 120,
  parameter int COOLDOWN  = 30,
  parameter int OFFSET    = 8,
  parameter int X_MIN     = 1,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 1,
  parameter int Y_MAX     = 479
) (
  input logic                   frame_clk,
  input logic                   Reset,
  tank_shell_scheduler_if.slave bus
);
  localparam int QUOTA = NUM_SLOTS / 2;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic [1:0]                fire_prev_q, fire_prev_d;
  logic [1:0]                pending_q, pending_d;
  logic                      rr_q, rr_d;
  logic [1:0][7:0]           cooldown_q, cooldown_d;
  logic [NUM_SLOTS-1:0]      busy_q, busy_d;
  logic [NUM_SLOTS-1:0]      owner_q, owner_d;
  logic [NUM_SLOTS-1:0][7:0] life_q, life_d;
  logic                      spawn_valid_q, spawn_valid_d;
  logic                      spawn_owner_q, spawn_owner_d;
  logic [2:0]                spawn_slot_q, spawn_slot_d;
  logic [9:0]                spawn_x_q, spawn_x_d;
  logic [9:0]                spawn_y_q, spawn_y_d;
  logic [1:0]                spawn_dir_q, spawn_dir_d;

  logic [1:0][CNT_W-1:0]     owned;
  logic [1:0]                press;
  logic [1:0]                eligible;
  logic                      free_any;
  logic [2:0]                free_idx;
  logic                      grant_any;
  logic                      grant_p;
  logic [9:0]                base_x, base_y;
  logic [1:0]                base_dir;
  int                        pos_x, pos_y;

  function automatic logic [9:0] sat(input int v, input int lo, input int hi);
    if (v < lo) return 10'(lo);
    if (v > hi) return 10'(hi);
    return 10'(v);
  endfunction

  always_comb begin
    owned    = '0;
    free_any = 1'b0;
    free_idx = '0;
    // Scan high to low so the last free slot seen is the lowest index.
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (busy_q[s]) begin
        owned[owner_q[s]] = owned[owner_q[s]] + CNT_W'(1);
      end else begin
        free_any = 1'b1;
        free_idx = 3'(s);
      end
    end

    press    = bus.fire_req & ~fire_prev_q;
    eligible = '0;
    for (int p = 0; p < 2; p++) begin
      eligible[p] = pending_q[p] && (owned[p] < CNT_W'(QUOTA)) && free_any;
    end
    grant_any = |eligible;
    grant_p   = (&eligible) ? rr_q : eligible[1];

    base_x   = grant_p ? bus.tank1_x   : bus.tank0_x;
    base_y   = grant_p ? bus.tank1_y   : bus.tank0_y;
    base_dir = grant_p ? bus.tank1_dir : bus.tank0_dir;
    pos_x    = int'(base_x);
    pos_y    = int'(base_y);
    case (base_dir)
      2'd0:    pos_y = pos_y - OFFSET;
      2'd1:    pos_x = pos_x - OFFSET;
      2'd2:    pos_y = pos_y + OFFSET;
      default: pos_x = pos_x + OFFSET;
    endcase

    fire_prev_d = bus.fire_req;
    rr_d        = grant_any ? ~grant_p : rr_q;

    pending_d  = '0;
    cooldown_d = cooldown_q;
    for (int p = 0; p < 2; p++) begin
      // Only a tie loser is eligible and ungranted; it keeps its request.
      pending_d[p] = (press[p] && cooldown_q[p] == 8'd0) ||
                     (eligible[p] && !(grant_any && grant_p == 1'(p)));
      if (grant_any && grant_p == 1'(p)) begin
        cooldown_d[p] = 8'(COOLDOWN);
      end else if (cooldown_q[p] != 8'd0) begin
        cooldown_d[p] = cooldown_q[p] - 8'd1;
      end
    end

    busy_d  = busy_q;
    owner_d = owner_q;
    life_d  = life_q;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (busy_q[s]) begin
        if (bus.hit[s] || life_q[s] == 8'd1) begin
          busy_d[s] = 1'b0;
          life_d[s] = 8'd0;
        end else begin
          life_d[s] = life_q[s] - 8'd1;
        end
      end
      if (grant_any && free_idx == 3'(s)) begin
        busy_d[s]  = 1'b1;
        owner_d[s] = grant_p;
        life_d[s]  = 8'(LIFETIME);
      end
    end

    spawn_valid_d = grant_any;
    spawn_slot_d  = spawn_slot_q;
    spawn_owner_d = spawn_owner_q;
    spawn_x_d     = spawn_x_q;
    spawn_y_d     = spawn_y_q;
    spawn_dir_d   = spawn_dir_q;
    if (grant_any) begin
      spawn_slot_d  = free_idx;
      spawn_owner_d = grant_p;
      spawn_x_d     = sat(pos_x, X_MIN, X_MAX);
      spawn_y_d     = sat(pos_y, Y_MIN, Y_MAX);
      spawn_dir_d   = base_dir;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      fire_prev_q   <= 2'b11;
      pending_q     <= '0;
      rr_q          <= 1'b0;
      cooldown_q    <= '0;
      busy_q        <= '0;
      owner_q       <= '0;
      life_q        <= '0;
      spawn_valid_q <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_owner_q <= 1'b0;
      spawn_x_q     <= '0;
      spawn_y_q     <= '0;
      spawn_dir_q   <= '0;
    end else begin
      fire_prev_q   <= fire_prev_d;
      pending_q     <= pending_d;
      rr_q          <= rr_d;
      cooldown_q    <= cooldown_d;
      busy_q        <= busy_d;
      owner_q       <= owner_d;
      life_q        <= life_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_slot_q  <= spawn_slot_d;
      spawn_owner_q <= spawn_owner_d;
      spawn_x_q     <= spawn_x_d;
      spawn_y_q     <= spawn_y_d;
      spawn_dir_q   <= spawn_dir_d;
    end
  end

  assign bus.spawn_valid = spawn_valid_q;
  assign bus.spawn_slot  = spawn_slot_q;
  assign bus.spawn_owner = spawn_owner_q;
  assign bus.spawn_x     = spawn_x_q;
  assign bus.spawn_y     = spawn_y_q;
  assign bus.spawn_dir   = spawn_dir_q;
  assign bus.slot_busy   = busy_q;
  assign bus.slot_owner  = owner_q;
endmodule

// File: tb/tb_tank_shell_scheduler.sv
// Two scheduler instances (long cooldown / zero cooldown) driven by the same
// stimulus and checked every frame against a behavioural model.
module tb_tank_shell_scheduler;
  localparam int NS   = 4;
  localparam int CD_A = 30;
  localparam int LT_A = 40;
  localparam int CD_B = 0;
  localparam int LT_B = 5;

  logic          frame_clk = 1'b0;
  logic          Reset;
  logic [1:0]    fire_r;
  logic [9:0]    tx [2];
  logic [9:0]    ty [2];
  logic [1:0]    td [2];
  logic [NS-1:0] hit_r;

  int n_checks = 0;
  int n_pass   = 0;

  tank_shell_scheduler_if #(.NUM_SLOTS(NS)) bus_a ();
  tank_shell_scheduler_if #(.NUM_SLOTS(NS)) bus_b ();

  assign {bus_a.fire_req, bus_a.hit} = {fire_r, hit_r};
  assign {bus_a.tank0_x, bus_a.tank0_y, bus_a.tank0_dir} = {tx[0], ty[0], td[0]};
  assign {bus_a.tank1_x, bus_a.tank1_y, bus_a.tank1_dir} = {tx[1], ty[1], td[1]};
  assign {bus_b.fire_req, bus_b.hit} = {fire_r, hit_r};
  assign {bus_b.tank0_x, bus_b.tank0_y, bus_b.tank0_dir} = {tx[0], ty[0], td[0]};
  assign {bus_b.tank1_x, bus_b.tank1_y, bus_b.tank1_dir} = {tx[1], ty[1], td[1]};

  tank_shell_scheduler #(.NUM_SLOTS(NS), .LIFETIME(LT_A), .COOLDOWN(CD_A)) dut_a (
    .frame_clk(frame_clk), .Reset(Reset), .bus(bus_a.slave));
  tank_shell_scheduler #(.NUM_SLOTS(NS), .LIFETIME(LT_B), .COOLDOWN(CD_B)) dut_b (
    .frame_clk(frame_clk), .Reset(Reset), .bus(bus_b.slave));

  always #5 frame_clk = ~frame_clk;

  // Reference state, index 0 = instance a, 1 = instance b.
  int m_fp [2][2];
  int m_pend [2][2];
  int m_cd [2][2];
  int m_rr [2];
  int m_busy [2][NS];
  int m_own [2][NS];
  int m_life [2][NS];
  int m_sv [2], m_ss [2], m_so [2], m_sx [2], m_sy [2], m_sd [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset(input int i);
    for (int p = 0; p < 2; p++) begin
      m_fp[i][p] = 1; m_pend[i][p] = 0; m_cd[i][p] = 0;
    end
    m_rr[i] = 0;
    for (int s = 0; s < NS; s++) begin
      m_busy[i][s] = 0; m_own[i][s] = 0; m_life[i][s] = 0;
    end
    m_sv[i] = 0; m_ss[i] = 0; m_so[i] = 0; m_sx[i] = 0; m_sy[i] = 0; m_sd[i] = 0;
  endtask

  task automatic model_step(input int i, input int cool, input int lt);
    int owned [2];
    int el [2];
    int np [2];
    int nfree, ff, g, x, y;
    owned[0] = 0; owned[1] = 0; nfree = 0; ff = -1;
    for (int s = 0; s < NS; s++) begin
      if (m_busy[i][s] != 0) owned[m_own[i][s]]++;
      else begin
        nfree++;
        if (ff < 0) ff = s;
      end
    end
    for (int p = 0; p < 2; p++)
      el[p] = (m_pend[i][p] != 0 && owned[p] < NS / 2 && nfree > 0) ? 1 : 0;
    g = -1;
    if (el[0] != 0 && el[1] != 0) g = m_rr[i];
    else if (el[0] != 0) g = 0;
    else if (el[1] != 0) g = 1;
    for (int p = 0; p < 2; p++) begin
      np[p] = ((fire_r[p] && m_fp[i][p] == 0 && m_cd[i][p] == 0) ||
               (el[p] != 0 && g != p)) ? 1 : 0;
      if (m_cd[i][p] > 0) m_cd[i][p]--;
    end
    for (int s = 0; s < NS; s++) begin
      if (m_busy[i][s] != 0) begin
        if (hit_r[s] || m_life[i][s] == 1) begin
          m_busy[i][s] = 0; m_life[i][s] = 0;
        end else m_life[i][s]--;
      end
    end
    m_sv[i] = 0;
    if (g >= 0) begin
      m_busy[i][ff] = 1; m_own[i][ff] = g; m_life[i][ff] = lt;
      m_cd[i][g] = cool; m_rr[i] = 1 - g;
      x = int'(tx[g]); y = int'(ty[g]);
      case (td[g])
        2'd0: y -= 8;
        2'd1: x -= 8;
        2'd2: y += 8;
        default: x += 8;
      endcase
      m_sv[i] = 1; m_ss[i] = ff; m_so[i] = g;
      m_sx[i] = sat(x, 1, 639); m_sy[i] = sat(y, 1, 479); m_sd[i] = int'(td[g]);
    end
    for (int p = 0; p < 2; p++) begin
      m_pend[i][p] = np[p];
      m_fp[i][p] = fire_r[p] ? 1 : 0;
    end
  endtask

  task automatic check_inst(input int i, input string nm, input logic sv, input logic [2:0] ss,
                            input logic so, input logic [9:0] sx, input logic [9:0] sy,
                            input logic [1:0] sd, input logic [NS-1:0] busy,
                            input logic [NS-1:0] own);
    int eb, eo;
    eb = 0; eo = 0;
    for (int s = 0; s < NS; s++) begin
      if (m_busy[i][s] != 0) begin
        eb |= (1 << s);
        if (m_own[i][s] != 0) eo |= (1 << s);
      end
    end
    check_eq({nm, ".spawn_valid"}, int'(sv), m_sv[i]);
    check_eq({nm, ".spawn_slot"}, int'(ss), m_ss[i]);
    check_eq({nm, ".spawn_owner"}, int'(so), m_so[i]);
    check_eq({nm, ".spawn_x"}, int'(sx), m_sx[i]);
    check_eq({nm, ".spawn_y"}, int'(sy), m_sy[i]);
    check_eq({nm, ".spawn_dir"}, int'(sd), m_sd[i]);
    check_eq({nm, ".slot_busy"}, int'(busy), eb);
    check_eq({nm, ".slot_owner"}, int'(own) & eb, eo);
  endtask

  task automatic check_both();
    check_inst(0, "a", bus_a.spawn_valid, bus_a.spawn_slot, bus_a.spawn_owner, bus_a.spawn_x,
               bus_a.spawn_y, bus_a.spawn_dir, bus_a.slot_busy, bus_a.slot_owner);
    check_inst(1, "b", bus_b.spawn_valid, bus_b.spawn_slot, bus_b.spawn_owner, bus_b.spawn_x,
               bus_b.spawn_y, bus_b.spawn_dir, bus_b.slot_busy, bus_b.slot_owner);
  endtask

  task automatic cycle();
    @(posedge frame_clk);
    model_step(0, CD_A, LT_A);
    model_step(1, CD_B, LT_B);
    #1;
    check_both();
  endtask

  // Asynchronous reset asserted between edges, released on the falling edge.
  task automatic pulse_reset();
    #2 Reset = 1'b1;
    model_reset(0);
    model_reset(1);
    #1 check_both();
    @(negedge frame_clk) Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    fire_r = 2'b00; hit_r = '0;
    tx[0] = 10'd100; ty[0] = 10'd200; td[0] = 2'd3;
    tx[1] = 10'd3;   ty[1] = 10'd4;   td[1] = 2'd0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge frame_clk);
    #1 check_both();
    @(negedge frame_clk) Reset = 1'b0;

    // Single fire from player 0.
    cycle();
    fire_r = 2'b01;
    cycle();
    check_eq("single.no_early_spawn", int'(bus_a.spawn_valid), 0);
    cycle();
    check_eq("single.valid", int'(bus_a.spawn_valid), 1);
    check_eq("single.x", int'(bus_a.spawn_x), 108);
    check_eq("single.y", int'(bus_a.spawn_y), 200);
    check_eq("single.busy", int'(bus_a.slot_busy), 1);
    fire_r = 2'b00;
    cycle();
    check_eq("single.one_frame", int'(bus_a.spawn_valid), 0);

    // Tie after reset: player 0 first, then player 1 with the clamped spawn point.
    pulse_reset();
    cycle();
    fire_r = 2'b11;
    cycle();
    cycle();
    check_eq("tie.first_owner", int'(bus_b.spawn_owner), 0);
    cycle();
    check_eq("tie.second_owner", int'(bus_b.spawn_owner), 1);
    check_eq("tie.second_slot", int'(bus_b.spawn_slot), 1);
    check_eq("clamp.y", int'(bus_b.spawn_y), 1);
    check_eq("tie.busy", int'(bus_b.slot_busy), 3);

    // Fire held through reset must be released before it fires again.
    pulse_reset();
    repeat (3) begin
      cycle();
      check_eq("held.no_spawn", int'(bus_a.spawn_valid), 0);
    end
    fire_r = 2'b00;
    cycle();
    fire_r = 2'b11;
    cycle();
    cycle();
    check_eq("held.rearm_spawn", int'(bus_a.spawn_valid), 1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        for (int p = 0; p < 2; p++) begin
          tx[p] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12)) : 10'($urandom_range(0, 1023));
          ty[p] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12)) : 10'($urandom_range(0, 1023));
          td[p] = 2'($urandom_range(0, 3));
        end
      end
      fire_r = 2'($urandom_range(0, 3));
      hit_r  = ($urandom_range(0, 5) == 0) ? NS'($urandom_range(0, (1 << NS) - 1)) : '0;
      cycle();
      if (n % 500 == 499) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
